stall_ctrl: RTL
===============

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: Clock  in  1  rising-edge clock; Reset  in  1  synchronous active-high reset.
REQ-002 SHALL provide ID-stage consumer ports: ID_Rs  in  5  rs number; ID_Rt  in  5  rt number; ID_TuseRs  in  2  cycles until rs needed (3 = unused); ID_TuseRt  in  2  same for rt; ID_IsMD  in  1  ID instr is mult/div/mfhi/mflo/mthi/mtlo.
REQ-003 SHALL provide EX-stage producer ports: EX_WriteReg  in  5  destination reg; EX_Tnew  in  2  cycles until result available; EX_Start  in  1  mult/div issuing this cycle; EX_IsDiv  in  1  issuing op is div/divu.
REQ-004 SHALL provide MEM-stage producer ports: MEM_WriteReg  in  5  destination reg; MEM_Tnew  in  2  cycles until result available.
REQ-005 SHALL provide outputs: IF_Enable  out  1  PC write enable; ID_Enable  out  1  IF/ID register enable; EX_Flush  out  1  insert bubble into ID/EX; Busy  out  1  mult/div unit busy; StallCount  out  32  stall-cycle performance counter.

Function
REQ-006 SHALL compute RsHazard = (ID_Rs != 0) and ((ID_Rs == EX_WriteReg and EX_Tnew > ID_TuseRs) or (ID_Rs == MEM_WriteReg and MEM_Tnew > ID_TuseRs)), combinationally.
REQ-007 SHALL compute RtHazard identically using ID_Rt and ID_TuseRt.
REQ-008 SHALL treat register 0 as never hazarding; ID_Tuse = 3 SHALL never hazard (Tnew max 2).
REQ-009 SHALL hold a 4-bit busy counter MDCnt, reset value 0.
REQ-010 On a rising edge with EX_Start = 1 and MDCnt = 0, MDCnt SHALL load 5 (EX_IsDiv = 0) or 10 (EX_IsDiv = 1).
REQ-011 On a rising edge with MDCnt != 0, MDCnt SHALL decrement by 1; EX_Start in that cycle SHALL be ignored (no reload).
REQ-012 Busy SHALL equal (MDCnt != 0) or EX_Start, combinationally.
REQ-013 MDHazard SHALL equal ID_IsMD and Busy.
REQ-014 Stall SHALL equal RsHazard or RtHazard or MDHazard.
REQ-015 IF_Enable and ID_Enable SHALL equal not Stall; EX_Flush SHALL equal Stall; same-cycle combinational, zero latency.
REQ-016 StallCount SHALL increment by 1 on every rising edge where Stall = 1, saturating at 32'hFFFFFFFF (no wrap).
REQ-017 Simultaneous data and MD hazards SHALL count as one stall cycle.
REQ-018 A stall lasting N cycles SHALL hold PC and IF/ID for exactly N edges and inject exactly N bubbles.

Reset
REQ-019 On a rising edge with Reset = 1, MDCnt and StallCount SHALL become 0, overriding EX_Start and Stall.
REQ-020 While Reset = 1, Stall SHALL be forced 0: IF_Enable = 1, ID_Enable = 1, EX_Flush = 0, Busy = 0.
REQ-021 Reset asserted mid mult/div SHALL abort the countdown; first edge after release sees MDCnt = 0.

Verification
REQ-022 Load-use: ID_Rs = 5, ID_TuseRs = 0, EX_WriteReg = 5, EX_Tnew = 2 -> IF_Enable = 0, EX_Flush = 1; next cycle MEM_WriteReg = 5, MEM_Tnew = 1, EX cleared -> still stalled; following cycle MEM_Tnew = 0 -> IF_Enable = 1; StallCount = 2.
REQ-023 Zero register: ID_Rt = 0, EX_WriteReg = 0, EX_Tnew = 2, ID_TuseRt = 0 -> no stall, StallCount unchanged.
REQ-024 Mult: EX_Start = 1, EX_IsDiv = 0 for one cycle, ID_IsMD = 1 held -> Busy = 1 and stall for 6 cycles (issue cycle + 5 countdown), then IF_Enable = 1 when MDCnt = 0.
REQ-025 Div: EX_Start = 1, EX_IsDiv = 1, ID_IsMD = 0 -> Busy high 11 cycles, no stall; second EX_Start while MDCnt = 7 -> MDCnt continues 6, 5, ... (no reload).
REQ-026 Reset mid-op: div started, Reset = 1 at MDCnt = 4 -> next edge MDCnt = 0, StallCount = 0, Busy = 0 during and after reset.
REQ-027 Saturation: force StallCount near max via 2^32-1 stall edges (or a bench-only preload) -> value holds at 32'hFFFFFFFF on further stalls.

Source files
------------

// File: rtl/stall_ctrl.sv
// Pipeline interlock: detects data hazards between the ID stage and its EX/MEM
// producers, tracks the multi-cycle mult/div unit, and counts stall cycles.
module stall_ctrl (
  input  logic        Clock,
  input  logic        Reset,
  // ID-stage consumer
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [1:0]  ID_TuseRs,
  input  logic [1:0]  ID_TuseRt,
  input  logic        ID_IsMD,
  // EX-stage producer
  input  logic [4:0]  EX_WriteReg,
  input  logic [1:0]  EX_Tnew,
  input  logic        EX_Start,
  input  logic        EX_IsDiv,
  // MEM-stage producer
  input  logic [4:0]  MEM_WriteReg,
  input  logic [1:0]  MEM_Tnew,
  // control and status
  output logic        IF_Enable,
  output logic        ID_Enable,
  output logic        EX_Flush,
  output logic        Busy,
  output logic [31:0] StallCount
);

  localparam logic [3:0]  MULT_CYCLES = 4'd5;
  localparam logic [3:0]  DIV_CYCLES  = 4'd10;
  localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        rs_hazard, rt_hazard, md_hazard, stall;

  // Register 0 never hazards; Tuse = 3 can never be exceeded since Tnew <= 2.
  always_comb begin
    rs_hazard = (ID_Rs != 5'd0) &&
                (((ID_Rs == EX_WriteReg)  && (EX_Tnew  > ID_TuseRs)) ||
                 ((ID_Rs == MEM_WriteReg) && (MEM_Tnew > ID_TuseRs)));
    rt_hazard = (ID_Rt != 5'd0) &&
                (((ID_Rt == EX_WriteReg)  && (EX_Tnew  > ID_TuseRt)) ||
                 ((ID_Rt == MEM_WriteReg) && (MEM_Tnew > ID_TuseRt)));
  end

  // Reset masks every combinational control output so the pipeline runs freely.
  assign Busy      = !Reset && ((md_cnt_q != 4'd0) || EX_Start);
  assign md_hazard = ID_IsMD && Busy;
  assign stall     = !Reset && (rs_hazard || rt_hazard || md_hazard);

  assign IF_Enable  = !stall;
  assign ID_Enable  = !stall;
  assign EX_Flush   = stall;
  assign StallCount = stall_cnt_q;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;
    // A start while the unit is counting down is ignored, never reloaded.
    if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else if (EX_Start) begin
      md_cnt_d = EX_IsDiv ? DIV_CYCLES : MULT_CYCLES;
    end
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next-state value from before the edge, independent of block order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
